regfile_wb_arbiter: RTL and testbench

Arbitrates two writeback requesters (ALU result, memory load) onto the single write port of the 8x10-bit register file, using round-robin priority. It also keeps a per-register busy scoreboard: the issue stage sets a bit when an instruction targeting that register is issued, and the bit clears when the write commits. The scoreboard drives read-hazard and write-after-write (WAW) stall signals back to decode/issue.

---
 rtl/cpu10_pkg.sv | 9 +
 rtl/rr_arb2.sv | 23 ++
 rtl/regfile_wb_arbiter.sv | 81 ++++++++
 tb/tb_regfile_wb_arbiter.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu10_pkg.sv
// rtl/cpu10_pkg.sv - shared widths and register-file types for the 10-bit core
package cpu10_pkg;
  localparam int DATA_W   = 10;
  localparam int ADDR_W   = 3;
  localparam int NUM_REGS = 1 << ADDR_W;

  typedef logic [ADDR_W-1:0] reg_addr_t;
  typedef logic [DATA_W-1:0] reg_data_t;
endpackage

// File: rtl/rr_arb2.sv
// rtl/rr_arb2.sv - two-requester round-robin arbiter with a registered priority pointer
module rr_arb2 (
  input  logic clk,
  input  logic reset,
  input  logic valid0,
  input  logic valid1,
  output logic ready0,
  output logic ready1
);
  logic prio;

  assign ready0 = valid0 & (~valid1 | ~prio);
  assign ready1 = valid1 & (~valid0 |  prio);

  // Only contention moves the pointer; it then names the requester that lost.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prio <= 1'b0;
    end else if (valid0 && valid1) begin
      prio <= ~prio;
    end
  end
endmodule

// File: rtl/regfile_wb_arbiter.sv
// rtl/regfile_wb_arbiter.sv - writeback arbiter and busy scoreboard; option REG0_READONLY_EN
module regfile_wb_arbiter
  import cpu10_pkg::*;
(
  input  logic                clk,
  input  logic                reset,
  input  logic                req0_valid,
  input  logic [ADDR_W-1:0]   req0_dest,
  input  logic [DATA_W-1:0]   req0_data,
  output logic                req0_ready,
  input  logic                req1_valid,
  input  logic [ADDR_W-1:0]   req1_dest,
  input  logic [DATA_W-1:0]   req1_data,
  output logic                req1_ready,
  input  logic                issue_valid,
  input  logic [ADDR_W-1:0]   issue_dest,
  output logic                issue_stall,
  input  logic [ADDR_W-1:0]   read_addr_1,
  input  logic [ADDR_W-1:0]   read_addr_2,
  output logic                read_stall,
  output logic                write_en,
  output logic [ADDR_W-1:0]   reg_write_dest,
  output logic [DATA_W-1:0]   write_data,
  output logic [NUM_REGS-1:0] busy_vec
);
`ifdef REG0_READONLY_EN
  localparam logic REG0_RO = 1'b1;
`else
  localparam logic REG0_RO = 1'b0;
`endif

  logic          accept;
  reg_addr_t     sel_dest;
  reg_data_t     sel_data;
  logic          issue_set;
  logic [NUM_REGS-1:0] busy_nxt;

  rr_arb2 u_arb (
    .clk    (clk),
    .reset  (reset),
    .valid0 (req0_valid),
    .valid1 (req1_valid),
    .ready0 (req0_ready),
    .ready1 (req1_ready)
  );

  assign accept   = req0_ready | req1_ready;
  assign sel_dest = req1_ready ? req1_dest : req0_dest;
  assign sel_data = req1_ready ? req1_data : req0_data;

  assign issue_stall = issue_valid & busy_vec[issue_dest];
  assign read_stall  = busy_vec[read_addr_1] | busy_vec[read_addr_2];
  assign issue_set   = issue_valid & ~issue_stall & ~(REG0_RO & (issue_dest == '0));

  // Clear first so a new producer issued on the commit edge keeps its bit.
  always_comb begin
    busy_nxt = busy_vec;
    if (write_en) begin
      busy_nxt[reg_write_dest] = 1'b0;
    end
    if (issue_set) begin
      busy_nxt[issue_dest] = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      write_en       <= 1'b0;
      reg_write_dest <= '0;
      write_data     <= '0;
      busy_vec       <= '0;
    end else begin
      busy_vec <= busy_nxt;
      write_en <= accept & ~(REG0_RO & (sel_dest == '0));
      if (accept) begin
        reg_write_dest <= sel_dest;
        write_data     <= sel_data;
      end
    end
  end
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// tb/tb_regfile_wb_arbiter.sv - randomized self-checking bench with a scoreboard reference model
module tb_regfile_wb_arbiter;
  import cpu10_pkg::*;

`ifdef REG0_READONLY_EN
  localparam bit RO = 1'b1;
`else
  localparam bit RO = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset;
  logic req0_valid, req1_valid, issue_valid;
  reg_addr_t req0_dest, req1_dest, issue_dest, read_addr_1, read_addr_2;
  reg_data_t req0_data, req1_data;
  logic req0_ready, req1_ready, issue_stall, read_stall, write_en;
  reg_addr_t reg_write_dest;
  reg_data_t write_data;
  logic [NUM_REGS-1:0] busy_vec;

  int checks = 0;
  int failures = 0;

  // reference state: who is owed the next tie, which registers have producers in flight,
  // and what the write port should be showing
  int  m_prio;
  bit  m_busy[NUM_REGS];
  bit  m_we;
  int  m_dest, m_data;
  bit  m_dd_known;
  int  last_win;

  regfile_wb_arbiter dut (
    .clk            (clk),
    .reset          (reset),
    .req0_valid     (req0_valid),
    .req0_dest      (req0_dest),
    .req0_data      (req0_data),
    .req0_ready     (req0_ready),
    .req1_valid     (req1_valid),
    .req1_dest      (req1_dest),
    .req1_data      (req1_data),
    .req1_ready     (req1_ready),
    .issue_valid    (issue_valid),
    .issue_dest     (issue_dest),
    .issue_stall    (issue_stall),
    .read_addr_1    (read_addr_1),
    .read_addr_2    (read_addr_2),
    .read_stall     (read_stall),
    .write_en       (write_en),
    .reg_write_dest (reg_write_dest),
    .write_data     (write_data),
    .busy_vec       (busy_vec)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] model_busy();
    logic [31:0] v = '0;
    for (int r = 0; r < NUM_REGS; r++) v[r] = m_busy[r];
    return v;
  endfunction

  task automatic model_reset();
    m_prio = 0;
    for (int r = 0; r < NUM_REGS; r++) m_busy[r] = 1'b0;
    m_we = 1'b0;
    m_dest = 0;
    m_data = 0;
    m_dd_known = 1'b1;
  endtask

  task automatic idle_inputs();
    req0_valid = 0; req0_dest = '0; req0_data = '0;
    req1_valid = 0; req1_dest = '0; req1_data = '0;
    issue_valid = 0; issue_dest = '0;
    read_addr_1 = '0; read_addr_2 = '0;
  endtask

  // Inputs are set by the caller; checks combinational outputs, clocks once, checks registers.
  task automatic cycle();
    bit both, exp_istall, set_ok;
    int win;
    #1;
    both = req0_valid && req1_valid;
    if (!req0_valid && !req1_valid) win = -1;
    else if (both) win = m_prio;
    else win = req0_valid ? 0 : 1;
    exp_istall = issue_valid && m_busy[issue_dest];
    check("req0_ready", req0_ready, win == 0);
    check("req1_ready", req1_ready, win == 1);
    check("one_ready", req0_ready & req1_ready, 0);
    check("issue_stall", issue_stall, exp_istall);
    check("read_stall", read_stall, m_busy[read_addr_1] || m_busy[read_addr_2]);
    @(posedge clk);
    set_ok = issue_valid && !exp_istall && !(RO && issue_dest == 0);
    if (m_we) m_busy[m_dest] = 1'b0;
    if (set_ok) m_busy[issue_dest] = 1'b1;
    if (win >= 0) begin
      m_dest = (win == 1) ? int'(req1_dest) : int'(req0_dest);
      m_data = (win == 1) ? int'(req1_data) : int'(req0_data);
      m_we   = !(RO && m_dest == 0);
      m_dd_known = m_we;
      if (both) m_prio = 1 - win;
    end else begin
      m_we = 1'b0;
    end
    last_win = win;
    #1;
    check("write_en", write_en, m_we);
    if (m_dd_known) begin
      check("reg_write_dest", reg_write_dest, m_dest);
      check("write_data", write_data, m_data);
    end
    check("busy_vec", busy_vec, model_busy());
  endtask

  task automatic do_reset();
    reset = 1'b1;
    #2;
    model_reset();
    check("rst_write_en", write_en, 0);
    check("rst_busy_vec", busy_vec, 0);
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  bit hold0, hold1;

  initial begin
    reset = 1'b1;
    idle_inputs();
    model_reset();
    #12;
    reset = 1'b0;
    @(posedge clk);
    #1;
    // reset then idle
    check("idle_write_en", write_en, 0);
    check("idle_busy", busy_vec, 8'h00);
    cycle();
    check("idle_req0_ready", req0_ready, 0);
    check("idle_req1_ready", req1_ready, 0);

    // issue to r3, commit two cycles later
    issue_valid = 1; issue_dest = 3;
    cycle();
    idle_inputs();
    check("sb_busy_c2", busy_vec, 8'h08);
    cycle();
    req0_valid = 1; req0_dest = 3; req0_data = 10'h0A5;
    cycle();
    idle_inputs();
    check("sb_busy_c4", busy_vec, 8'h08);
    check("sb_we_c4", write_en, 1);
    check("sb_dest_c4", reg_write_dest, 3);
    check("sb_data_c4", write_data, 10'h0A5);
    cycle();
    check("sb_busy_c5", busy_vec, 8'h00);
    check("hold_dest", reg_write_dest, 3);

    // contention: grants alternate req0, req1, req0
    req0_valid = 1; req0_dest = 1; req0_data = 10'h011;
    req1_valid = 1; req1_dest = 2; req1_data = 10'h022;
    cycle();
    check("rr_dest_a", reg_write_dest, 1);
    req0_data = 10'h012;
    cycle();
    check("rr_dest_b", reg_write_dest, 2);
    req1_data = 10'h023;
    cycle();
    check("rr_dest_c", reg_write_dest, 1);
    check("rr_data_c", write_data, 10'h012);
    idle_inputs();
    cycle();

    // read hazard and WAW stall on r5
    issue_valid = 1; issue_dest = 5;
    cycle();
    read_addr_1 = 5; read_addr_2 = 0;
    #1;
    check("raw_read_stall", read_stall, 1);
    check("waw_issue_stall", issue_stall, 1);
    cycle();
    check("waw_no_reset", busy_vec, 8'h20);
    idle_inputs();
    req1_valid = 1; req1_dest = 5; req1_data = 10'h155;
    cycle();
    idle_inputs();
    cycle();
    check("r5_cleared", busy_vec, 8'h00);

    // spurious commit of r4 on the same edge as a new issue to r4: set wins
    req0_valid = 1; req0_dest = 4; req0_data = 10'h044;
    cycle();
    idle_inputs();
    issue_valid = 1; issue_dest = 4;
    cycle();
    idle_inputs();
    check("set_wins_r4", busy_vec[4], 1);
    req0_valid = 1; req0_dest = 4; req0_data = 10'h045;
    cycle();
    idle_inputs();
    cycle();
    check("r4_cleared", busy_vec, 8'h00);

    // register 0 handling
    req1_valid = 1; req1_dest = 0; req1_data = 10'h3FF;
    #1;
    check("r0_req1_ready", req1_ready, 1);
    cycle();
    idle_inputs();
    check("r0_write_en", write_en, RO ? 0 : 1);
    issue_valid = 1; issue_dest = 0;
    cycle();
    idle_inputs();
    check("r0_busy", busy_vec[0], RO ? 0 : 1);
    cycle();
    do_reset();

    // reset mid-transfer: write_en must fall without waiting for a clock
    req0_valid = 1; req0_dest = 6; req0_data = 10'h266;
    issue_valid = 1; issue_dest = 6;
    cycle();
    idle_inputs();
    check("mid_we_before", write_en, 1);
    do_reset();

    // randomized traffic honouring the hold-until-accepted rule
    hold0 = 0; hold1 = 0;
    for (int n = 0; n < 400; n++) begin
      if (!hold0) begin
        req0_valid = ($urandom_range(0, 1) == 1);
        req0_dest  = reg_addr_t'($urandom_range(0, NUM_REGS - 1));
        req0_data  = reg_data_t'($urandom);
      end
      if (!hold1) begin
        req1_valid = ($urandom_range(0, 1) == 1);
        req1_dest  = reg_addr_t'($urandom_range(0, NUM_REGS - 1));
        req1_data  = reg_data_t'($urandom);
      end
      issue_valid = ($urandom_range(0, 2) == 0);
      issue_dest  = reg_addr_t'($urandom_range(0, NUM_REGS - 1));
      read_addr_1 = reg_addr_t'($urandom_range(0, NUM_REGS - 1));
      read_addr_2 = reg_addr_t'($urandom_range(0, NUM_REGS - 1));
      cycle();
      hold0 = req0_valid && (last_win != 0);
      hold1 = req1_valid && (last_win != 1);
      if (n == 200) begin
        do_reset();
        idle_inputs();
        hold0 = 0; hold1 = 0;
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
